// File: rtl/button_debounce_monitor_nbit_pkg.sv
// Shared constants, state encodings and width helpers for the button debounce monitor.
package button_debounce_monitor_nbit_pkg;

  // Default timing for a 50 MHz system clock.
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250_000;     // 5 ms
  localparam int DEFAULT_LONG_CYCLES     = 50_000_000;  // 1 s
  localparam int DEFAULT_REPEAT_CYCLES   = 10_000_000;  // 200 ms

  // Per-channel debounce FSM encodings.
  localparam logic [1:0] ST_RELEASED        = 2'd0;
  localparam logic [1:0] ST_PRESS_PENDING   = 2'd1;
  localparam logic [1:0] ST_PRESSED         = 2'd2;
  localparam logic [1:0] ST_RELEASE_PENDING = 2'd3;

  typedef enum logic [1:0] {
    RELEASED        = ST_RELEASED,
    PRESS_PENDING   = ST_PRESS_PENDING,
    PRESSED         = ST_PRESSED,
    RELEASE_PENDING = ST_RELEASE_PENDING
  } btn_state_e;

  // Bits needed for a counter that must be able to hold max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: synchroniser, debounce FSM, hold/long-press and auto-repeat timing.
module button_debounce_channel
  import button_debounce_monitor_nbit_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic button_raw,
  input  logic repeat_en,
  output logic state_o,
  output logic edge_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_CYCLES + REPEAT_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  btn_state_e             state_q, state_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   long_done_q, long_done_d;
  logic                   level_q, level_d;
  logic                   edge_q, edge_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic                   repeat_q, repeat_d;
  logic                   sync_bit;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], button_raw};
  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Next-state: debounce FSM, then hold timing (long press first, then repeat period).
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    edge_d      = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      RELEASED: begin
        if (sync_bit) begin
          state_d  = PRESS_PENDING;
          db_cnt_d = '0;
        end
      end
      PRESS_PENDING: begin
        if (!sync_bit) begin
          state_d = RELEASED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = PRESSED;
          level_d     = 1'b1;
          edge_d      = 1'b1;
          hold_d      = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync_bit) begin
          state_d  = RELEASE_PENDING;
          db_cnt_d = '0;
        end
      end
      RELEASE_PENDING: begin
        if (sync_bit) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase

    // The hold counter keeps running through a release bounce so a long press
    // is not restarted; the repeat counter runs even when repeat is disabled
    // so that enabling mid-hold stays aligned to the long-press pulse.
    if ((state_q == PRESSED || state_q == RELEASE_PENDING) && state_d != RELEASED) begin
      if (!long_done_q) begin
        if (hold_q == LONG_LAST) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
          hold_d      = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end else begin
        if (hold_q == REP_LAST) begin
          repeat_d = repeat_en;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end

    if (state_d == RELEASED) begin
      hold_d      = '0;
      long_done_d = 1'b0;
    end
  end

  // State and registered outputs, all cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      state_q     <= RELEASED;
      db_cnt_q    <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      edge_q      <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      edge_q      <= edge_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign state_o   = level_q;
  assign edge_o    = edge_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_debounce_monitor_nbit.sv
// WIDTH independent debounced button channels with press/release/long/repeat pulses.
module button_debounce_monitor_nbit
  import button_debounce_monitor_nbit_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttonPress,
  input  logic [WIDTH-1:0] repeatEnable,
  output logic [WIDTH-1:0] buttonState,
  output logic [WIDTH-1:0] buttonEdge,
  output logic [WIDTH-1:0] buttonRelease,
  output logic [WIDTH-1:0] buttonLong,
  output logic [WIDTH-1:0] buttonRepeat
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    button_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .button_raw(buttonPress[i]),
      .repeat_en (repeatEnable[i]),
      .state_o   (buttonState[i]),
      .edge_o    (buttonEdge[i]),
      .release_o (buttonRelease[i]),
      .long_o    (buttonLong[i]),
      .repeat_o  (buttonRepeat[i])
    );
  end

endmodule

// File: tb/tb_button_debounce_monitor_nbit.sv
// Self-checking bench for button_debounce_monitor_nbit with a window-based reference model.
module tb_button_debounce_monitor_nbit;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int REP   = 8;
  localparam int LAT   = SYNC + DEB;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] buttonPress  = '0;
  logic [WIDTH-1:0] repeatEnable = '0;
  logic [WIDTH-1:0] buttonState, buttonEdge, buttonRelease, buttonLong, buttonRepeat;

  int cmp_count  = 0;
  int fail_count = 0;

  always #5 clock = ~clock;

  button_debounce_monitor_nbit #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .buttonPress  (buttonPress),
    .repeatEnable (repeatEnable),
    .buttonState  (buttonState),
    .buttonEdge   (buttonEdge),
    .buttonRelease(buttonRelease),
    .buttonLong   (buttonLong),
    .buttonRepeat (buttonRepeat)
  );

  // Reference model: a level is accepted once the synchronised input has held
  // the new value for DEB+1 consecutive samples; long/repeat come from the age
  // of the press measured in cycles since acceptance.
  logic [WIDTH-1:0] exp_state = '0, exp_edge = '0, exp_rel = '0, exp_long = '0, exp_rep = '0;
  bit   dly_q [WIDTH][$];
  bit   run_val [WIDTH];
  int   run_len [WIDTH];
  int   age     [WIDTH];
  bit   m_s;

  wire [5*WIDTH-1:0] obs_all = {buttonState, buttonEdge, buttonRelease, buttonLong, buttonRepeat};
  wire [5*WIDTH-1:0] exp_all = {exp_state, exp_edge, exp_rel, exp_long, exp_rep};

  task automatic model_clear();
    exp_state = '0; exp_edge = '0; exp_rel = '0; exp_long = '0; exp_rep = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dly_q[i] = {};
      for (int j = 0; j < SYNC; j++) dly_q[i].push_back(1'b0);
      run_val[i] = 1'b0;
      run_len[i] = 0;
      age[i]     = 0;
    end
  endtask

  // Model advances once per rising edge, using the inputs as seen at that edge.
  always @(posedge clock) begin
    if (!reset) begin
      model_clear();
    end else begin
      exp_edge = '0; exp_rel = '0; exp_long = '0; exp_rep = '0;
      for (int i = 0; i < WIDTH; i++) begin
        m_s = dly_q[i].pop_front();
        dly_q[i].push_back(buttonPress[i]);
        if (m_s == run_val[i]) run_len[i]++;
        else begin
          run_val[i] = m_s;
          run_len[i] = 1;
        end
        if (run_val[i] != exp_state[i] && run_len[i] >= DEB + 1) begin
          exp_state[i] = run_val[i];
          if (run_val[i]) begin
            exp_edge[i] = 1'b1;
            age[i]      = 0;
          end else begin
            exp_rel[i] = 1'b1;
          end
        end else if (exp_state[i]) begin
          age[i]++;
          if (age[i] == LONG) exp_long[i] = 1'b1;
          else if (age[i] > LONG && (age[i] - LONG) % REP == 0) exp_rep[i] = repeatEnable[i];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    buttonPress = '0;
    repeatEnable = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      cmp_count++;
      if (obs_all !== '0) begin
        fail_count++;
        $display("[TB] FAIL reset_outputs cyc %0d: got %h want 0", k, obs_all);
      end
    end
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL reset_idle cyc %0d: got %h want %h", k, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_clean_press();
    int edge_at, edge_cnt, rise_at, rel_at;
    edge_at = -1; edge_cnt = 0; rise_at = -1; rel_at = -1;
    buttonPress = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL clean_press cyc %0d: got %h want %h", k, obs_all, exp_all);
      end
      if (buttonEdge[0]) begin edge_cnt++; edge_at = k; end
      if (buttonState[0] && rise_at < 0) rise_at = k;
    end
    buttonPress = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL clean_release cyc %0d: got %h want %h", k, obs_all, exp_all);
      end
      if (buttonRelease[0]) rel_at = k;
    end
    cmp_count++;
    if (edge_at !== LAT || edge_cnt !== 1) begin
      fail_count++;
      $display("[TB] FAIL clean_edge_latency: got cyc %0d count %0d want cyc %0d count 1", edge_at, edge_cnt, LAT);
    end
    cmp_count++;
    if (rise_at !== LAT) begin
      fail_count++;
      $display("[TB] FAIL clean_state_rise: got cyc %0d want %0d", rise_at, LAT);
    end
    cmp_count++;
    if (rel_at !== LAT) begin
      fail_count++;
      $display("[TB] FAIL clean_release_latency: got cyc %0d want %0d", rel_at, LAT);
    end
  endtask

  task automatic test_bounce();
    int edge_at, edge_cnt, rel_cnt;
    edge_at = -1; edge_cnt = 0; rel_cnt = 0;
    for (int k = 0; k < 31; k++) begin
      buttonPress = (k < 15) ? {2'b00, (k % 3) != 2, 1'b0} : 4'b0010;
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL bounce cyc %0d: got %h want %h", k, obs_all, exp_all);
      end
      if (buttonEdge[1]) begin edge_cnt++; edge_at = k; end
      if (buttonRelease[1]) rel_cnt++;
    end
    cmp_count++;
    if (edge_cnt !== 1 || edge_at - 15 !== LAT) begin
      fail_count++;
      $display("[TB] FAIL bounce_edge: got count %0d offset %0d want count 1 offset %0d", edge_cnt, edge_at - 15, LAT);
    end
    cmp_count++;
    if (rel_cnt !== 0) begin
      fail_count++;
      $display("[TB] FAIL bounce_release: got %0d want 0", rel_cnt);
    end
    buttonPress = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL bounce_settle cyc %0d: got %h want %h", k, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_long_repeat(input bit en);
    int edge_at, long_at, long_cnt, rep_cnt, first_rep, last_rep, want_reps;
    edge_at = -1; long_at = -1; long_cnt = 0; rep_cnt = 0; first_rep = -1; last_rep = -1;
    want_reps = en ? 3 : 0;
    repeatEnable = en ? 4'b0100 : 4'b0000;
    buttonPress = 4'b0100;
    for (int k = 0; k < 62; k++) begin
      if (k == 48) buttonPress = 4'b0000;
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL long_repeat en=%0d cyc %0d: got %h want %h", en, k, obs_all, exp_all);
      end
      if (buttonEdge[2]) edge_at = k;
      if (buttonLong[2]) begin long_cnt++; long_at = k; end
      if (buttonRepeat[2]) begin
        rep_cnt++;
        if (first_rep < 0) first_rep = k;
        last_rep = k;
      end
    end
    cmp_count++;
    if (long_cnt !== 1 || long_at - edge_at !== LONG) begin
      fail_count++;
      $display("[TB] FAIL long_pulse en=%0d: got count %0d offset %0d want count 1 offset %0d", en, long_cnt, long_at - edge_at, LONG);
    end
    cmp_count++;
    if (rep_cnt !== want_reps) begin
      fail_count++;
      $display("[TB] FAIL repeat_count en=%0d: got %0d want %0d", en, rep_cnt, want_reps);
    end
    if (en) begin
      cmp_count++;
      if (first_rep - long_at !== REP || last_rep - long_at !== 3 * REP) begin
        fail_count++;
        $display("[TB] FAIL repeat_spacing: got first +%0d last +%0d want +%0d +%0d", first_rep - long_at, last_rep - long_at, REP, 3 * REP);
      end
    end
    repeatEnable = '0;
  endtask

  task automatic test_simultaneous();
    int edge_at, edge_cycles;
    edge_at = -1; edge_cycles = 0;
    buttonPress = 4'b1111;
    for (int k = 0; k < 22; k++) begin
      if (k == 10) buttonPress = 4'b0000;
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL simultaneous cyc %0d: got %h want %h", k, obs_all, exp_all);
      end
      if (buttonEdge !== 4'b0000) edge_cycles++;
      if (buttonEdge === 4'b1111) edge_at = k;
    end
    cmp_count++;
    if (edge_at !== LAT || edge_cycles !== 1) begin
      fail_count++;
      $display("[TB] FAIL simultaneous_edge: got cyc %0d cycles %0d want cyc %0d cycles 1", edge_at, edge_cycles, LAT);
    end
  endtask

  task automatic test_reset_mid();
    int e3_at, e3_cnt, e0_at;
    e3_at = -1; e3_cnt = 0; e0_at = -1;
    buttonPress = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) buttonPress = 4'b1001;
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL reset_mid_pre cyc %0d: got %h want %h", k, obs_all, exp_all);
      end
    end
    reset = 1'b0;
    #1;
    cmp_count++;
    if (obs_all !== '0) begin
      fail_count++;
      $display("[TB] FAIL async_clear: got %h want 0", obs_all);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      cmp_count++;
      if (obs_all !== '0 || exp_all !== '0) begin
        fail_count++;
        $display("[TB] FAIL reset_hold cyc %0d: got %h want 0", k, obs_all);
      end
    end
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL reset_mid_post cyc %0d: got %h want %h", k, obs_all, exp_all);
      end
      if (buttonEdge[3]) begin e3_cnt++; e3_at = k; end
      if (buttonEdge[0]) e0_at = k;
    end
    cmp_count++;
    if (e3_at !== LAT || e3_cnt !== 1 || e0_at !== LAT) begin
      fail_count++;
      $display("[TB] FAIL reset_redebounce: got ch3 cyc %0d count %0d ch0 cyc %0d want %0d/1/%0d", e3_at, e3_cnt, e0_at, LAT, LAT);
    end
    buttonPress = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL reset_mid_settle cyc %0d: got %h want %h", k, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_random();
    int timer [WIDTH];
    for (int i = 0; i < WIDTH; i++) timer[i] = $urandom_range(1, 10);
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        timer[i]--;
        if (timer[i] <= 0) begin
          buttonPress[i] = ~buttonPress[i];
          timer[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 70) : $urandom_range(1, 8);
        end
        if ($urandom_range(0, 39) == 0) repeatEnable[i] = ~repeatEnable[i];
      end
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL random cyc %0d: got %h want %h", k, obs_all, exp_all);
      end
    end
    buttonPress = '0;
    repeatEnable = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      cmp_count++;
      if (obs_all !== exp_all) begin
        fail_count++;
        $display("[TB] FAIL random_settle cyc %0d: got %h want %h", k, obs_all, exp_all);
      end
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat(1'b1);
    test_long_repeat(1'b0);
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
